// File: rtl/comp_arbiter.sv
// Round-robin arbiter sharing one single-entry comp unit among NUM_REQ lanes.
// Optional per-lane grant counters are enabled by defining ARB_STATS_EN.
module comp_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_b_i,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  input  logic [NUM_REQ-1:0]            rsp_ready_i,
  output logic                          comp_valid_o,
  input  logic                          comp_ready_i,
  output logic [DATA_WIDTH-1:0]         comp_data_a_o,
  output logic [DATA_WIDTH-1:0]         comp_data_b_o,
  input  logic                          comp_valid_i,
  input  logic [DATA_WIDTH-1:0]         comp_data_i,
  output logic                          comp_ready_o,
  output logic                          busy_o
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0]  grant_cnt_o
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [IDW-1:0]        r_gntId;
  logic [IDW-1:0]        r_lastGrant;
  logic [IDW-1:0]        w_winner;
  logic                  w_found;
  logic                  w_accept;
  logic                  w_done;
  int                    w_idx;
  logic [DATA_WIDTH-1:0] r_opA;
  logic [DATA_WIDTH-1:0] r_opB;

  // Search starts just after the previous owner so every held request is reached.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = (int'(r_lastGrant) + k) % NUM_REQ;
      if (!w_found && req_valid_i[w_idx]) begin
        w_found  = 1'b1;
        w_winner = IDW'(w_idx);
      end
    end
  end

  assign w_accept = (r_state == IDLE) && w_found;
  assign w_done   = (r_state == WAIT) && comp_valid_i && rsp_ready_i[r_gntId];

  always_comb begin
    w_nextState  = r_state;
    req_ready_o  = '0;
    rsp_valid_o  = '0;
    comp_valid_o = 1'b0;
    comp_ready_o = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          req_ready_o[w_winner] = 1'b1;
          w_nextState           = ISSUE;
        end
      end
      ISSUE: begin
        comp_valid_o = 1'b1;
        if (comp_ready_i) w_nextState = WAIT;
      end
      WAIT: begin
        rsp_valid_o[r_gntId] = comp_valid_i;
        comp_ready_o         = rsp_ready_i[r_gntId];
        if (w_done) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Operands load only on accept so the comp sees stable inputs until WAIT exits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gntId     <= '0;
      r_lastGrant <= IDW'(NUM_REQ - 1);
      r_opA       <= '0;
      r_opB       <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_gntId <= w_winner;
        r_opA   <= req_data_a_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
        r_opB   <= req_data_b_i[w_winner*DATA_WIDTH +: DATA_WIDTH];
      end
      if (w_done) r_lastGrant <= r_gntId;
    end
  end

  assign busy_o        = (r_state != IDLE);
  assign comp_data_a_o = r_opA;
  assign comp_data_b_o = r_opB;
  assign rsp_data_o    = comp_data_i;

`ifdef ARB_STATS_EN
  logic [NUM_REQ*CNT_WIDTH-1:0] r_grantCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grantCnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_accept && (w_winner == IDW'(i)))
          r_grantCnt[i*CNT_WIDTH +: CNT_WIDTH] <= r_grantCnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
      end
    end
  end

  assign grant_cnt_o = r_grantCnt;
`endif

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed self-checking bench for comp_arbiter with a small echo-style comp model.
// Stats checks are compiled in only when ARB_STATS_EN is defined.
module tb_comp_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int CW = 16;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    reqValid;
  logic [NR-1:0]    reqReady;
  logic [NR*DW-1:0] reqDataA;
  logic [NR*DW-1:0] reqDataB;
  logic [NR-1:0]    rspValid;
  logic [DW-1:0]    rspData;
  logic [NR-1:0]    rspReady;
  logic             compValidO;
  logic             compReadyI;
  logic [DW-1:0]    compDataA;
  logic [DW-1:0]    compDataB;
  logic             compValidI;
  logic [DW-1:0]    compDataI;
  logic             compReadyO;
  logic             busy;
  logic             compBusy;
`ifdef ARB_STATS_EN
  logic [NR*CW-1:0] grantCnt;
`endif

  int checks;
  int errors;

  comp_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (reqValid),
    .req_ready_o  (reqReady),
    .req_data_a_i (reqDataA),
    .req_data_b_i (reqDataB),
    .rsp_valid_o  (rspValid),
    .rsp_data_o   (rspData),
    .rsp_ready_i  (rspReady),
    .comp_valid_o (compValidO),
    .comp_ready_i (compReadyI),
    .comp_data_a_o(compDataA),
    .comp_data_b_o(compDataB),
    .comp_valid_i (compValidI),
    .comp_data_i  (compDataI),
    .comp_ready_o (compReadyO),
    .busy_o       (busy)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt_o  (grantCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-entry comp stand-in: echoes the live operand a while holding a result.
  always @(posedge clk or posedge rst) begin
    if (rst) compBusy <= 1'b0;
    else if (!compBusy && compValidO) compBusy <= 1'b1;
    else if (compBusy && compReadyO) compBusy <= 1'b0;
  end
  assign compReadyI = !compBusy;
  assign compValidI = compBusy;
  assign compDataI  = compBusy ? compDataA : '0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR-1:0] ready);
    reqValid = valid;
    rspReady = ready;
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    reqValid = '0;
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic runOp(input int lane);
    applyStimulus(4'b0001 << lane, 4'b1111);
    step();
    applyStimulus(4'b0000, 4'b1111);
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    reqValid = '0;
    rspReady = '0;
    reqDataA = '0;
    reqDataB = '0;
    #2;
    resetDut();

    // Reset state
    checkOutput("rst_req_ready", 64'(reqReady), 64'h0);
    checkOutput("rst_rsp_valid", 64'(rspValid), 64'h0);
    checkOutput("rst_comp_valid", 64'(compValidO), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_op_a", compDataA, 64'h0);

    // Single request latency
    reqDataA[0*DW +: DW] = 64'h11;
    reqDataB[0*DW +: DW] = 64'h22;
    applyStimulus(4'b0001, 4'b1111);
    checkOutput("t1_req_ready", 64'(reqReady), 64'h1);
    step();
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("t1_comp_valid", 64'(compValidO), 64'h1);
    checkOutput("t1_op_a", compDataA, 64'h11);
    checkOutput("t1_op_b", compDataB, 64'h22);
    checkOutput("t1_busy", 64'(busy), 64'h1);
    step();
    checkOutput("t1_rsp_valid", 64'(rspValid), 64'h1);
    checkOutput("t1_rsp_data", rspData, 64'h11);
    checkOutput("t1_comp_ready", 64'(compReadyO), 64'h1);
    step();
    checkOutput("t1_idle_busy", 64'(busy), 64'h0);
    checkOutput("t1_idle_rsp", 64'(rspValid), 64'h0);

    // All four held valid from reset: grant order 0,1,2,3,0
    resetDut();
    for (int i = 0; i < NR; i++) reqDataA[i*DW +: DW] = 64'hA0 + 64'(i);
    applyStimulus(4'b1111, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("t2_grant%0d", k), 64'(reqReady), 64'h1 << (k % NR));
      step();
      step();
      checkOutput($sformatf("t2_rsp%0d", k), 64'(rspValid), 64'h1 << (k % NR));
      checkOutput($sformatf("t2_data%0d", k), rspData, 64'hA0 + 64'(k % NR));
      step();
    end

    // Owner stall on lane 2 while lane 1 waits
    resetDut();
    reqDataA[2*DW +: DW] = 64'h2A;
    reqDataA[1*DW +: DW] = 64'h1A;
    applyStimulus(4'b0100, 4'b1011);
    checkOutput("t3_grant2", 64'(reqReady), 64'h4);
    step();
    applyStimulus(4'b0010, 4'b1011);
    checkOutput("t3_issue_rdy", 64'(reqReady), 64'h0);
    step();
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("t3_stall_rsp%0d", c), 64'(rspValid), 64'h4);
      checkOutput($sformatf("t3_stall_data%0d", c), rspData, 64'h2A);
      checkOutput($sformatf("t3_stall_req%0d", c), 64'(reqReady), 64'h0);
      checkOutput($sformatf("t3_stall_crdy%0d", c), 64'(compReadyO), 64'h0);
      step();
    end
    applyStimulus(4'b0010, 4'b1111);
    checkOutput("t3_release", 64'(compReadyO), 64'h1);
    step();
    checkOutput("t3_grant1", 64'(reqReady), 64'h2);
    step();
    applyStimulus(4'b0000, 4'b1111);
    step();
    checkOutput("t3_rsp1", 64'(rspValid), 64'h2);
    checkOutput("t3_data1", rspData, 64'h1A);
    step();

    // Operand hold after accept
    resetDut();
    reqDataA[0*DW +: DW] = 64'h55;
    reqDataB[0*DW +: DW] = 64'h66;
    applyStimulus(4'b0001, 4'b1111);
    step();
    reqDataA[0*DW +: DW] = 64'h99;
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("t4_issue_a", compDataA, 64'h55);
    checkOutput("t4_issue_b", compDataB, 64'h66);
    step();
    checkOutput("t4_wait_a", compDataA, 64'h55);
    checkOutput("t4_rsp_data", rspData, 64'h55);
    checkOutput("t4_rsp_valid", 64'(rspValid), 64'h1);
    step();

    // Reset while waiting for a result
    resetDut();
    reqDataA[2*DW +: DW] = 64'h77;
    applyStimulus(4'b0100, 4'b0000);
    step();
    applyStimulus(4'b0000, 4'b0000);
    step();
    checkOutput("t5_pre_rsp", 64'(rspValid), 64'h4);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_rsp", 64'(rspValid), 64'h0);
    checkOutput("t5_rst_cvalid", 64'(compValidO), 64'h0);
    checkOutput("t5_rst_cready", 64'(compReadyO), 64'h0);
    checkOutput("t5_rst_busy", 64'(busy), 64'h0);
    checkOutput("t5_rst_op_a", compDataA, 64'h0);
    step();
    rst = 1'b0;
    reqDataA[0*DW +: DW] = 64'h3C;
    applyStimulus(4'b0101, 4'b1111);
    checkOutput("t5_grant0", 64'(reqReady), 64'h1);
    step();
    applyStimulus(4'b0000, 4'b1111);
    checkOutput("t5_no_stale", 64'(rspValid), 64'h0);
    step();
    checkOutput("t5_rsp0", 64'(rspValid), 64'h1);
    checkOutput("t5_data0", rspData, 64'h3C);
    step();

`ifdef ARB_STATS_EN
    // Per-lane grant counters
    resetDut();
    runOp(1);
    runOp(1);
    runOp(1);
    runOp(3);
    checkOutput("t6_cnt0", 64'(grantCnt[0*CW +: CW]), 64'd0);
    checkOutput("t6_cnt1", 64'(grantCnt[1*CW +: CW]), 64'd3);
    checkOutput("t6_cnt2", 64'(grantCnt[2*CW +: CW]), 64'd0);
    checkOutput("t6_cnt3", 64'(grantCnt[3*CW +: CW]), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
